// File: rtl/ivt_vector_fetch.sv
`timescale 1ns/1ps
// IVT read client: reads word {core,vec}; a zero entry is retried once at {core,UNINIT_VEC}.
// Latency RD_LAT+2 clocks from accept (+RD_LAT+1 per retry); single request in flight, result held until ack_i.
module ivt_vector_fetch #(
  parameter int CORE_BITS  = 5,
  parameter int VEC_BITS   = 8,
  parameter int RD_LAT     = 2,
  parameter int UNINIT_VEC = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  input  logic [CORE_BITS-1:0]          core_i,
  input  logic [VEC_BITS-1:0]           vec_i,
  output logic                          rdy_o,
  output logic                          vld_o,
  input  logic                          ack_i,
  output logic [31:0]                   vector_o,
  output logic [1:0]                    err_o,
  output logic                          ram_en_o,
  output logic [CORE_BITS+VEC_BITS-1:0] ram_addr_o,
  input  logic [31:0]                   ram_dout_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [VEC_BITS-1:0] UNINIT_IDX = VEC_BITS'(UNINIT_VEC);
  localparam logic [2:0]          LAT_M1     = 3'(RD_LAT - 1);

  state_t                        r_state;
  logic [CORE_BITS-1:0]          r_core;
  logic                          r_retry;
  logic [2:0]                    r_cnt;
  logic                          r_rdy;
  logic                          r_vld;
  logic [31:0]                   r_vector;
  logic [1:0]                    r_err;
  logic                          r_ram_en;
  logic [CORE_BITS+VEC_BITS-1:0] r_ram_addr;

  // ram_en/ram_addr are loaded on the edge entering ISSUE so the pulse lines up with that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_core     <= '0;
      r_retry    <= 1'b0;
      r_cnt      <= '0;
      r_rdy      <= 1'b1;
      r_vld      <= 1'b0;
      r_vector   <= '0;
      r_err      <= 2'b00;
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
    end else begin
      r_ram_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_core     <= core_i;
            r_retry    <= 1'b0;
            r_rdy      <= 1'b0;
            r_ram_en   <= 1'b1;
            r_ram_addr <= {core_i, vec_i};
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= LAT_M1;
          r_state <= (RD_LAT == 1) ? S_CAPT : S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) r_state <= S_CAPT;
        end
        S_CAPT: begin
          if (ram_dout_i != 32'd0) begin
            r_vector <= ram_dout_i;
            r_err    <= r_retry ? 2'b01 : 2'b00;
            r_vld    <= 1'b1;
            r_state  <= S_DONE;
          end else if (!r_retry) begin
            r_retry    <= 1'b1;
            r_ram_en   <= 1'b1;
            r_ram_addr <= {r_core, UNINIT_IDX};
            r_state    <= S_ISSUE;
          end else begin
            r_vector <= 32'd0;
            r_err    <= 2'b10;
            r_vld    <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack_i) begin
            r_vld   <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdy_o      = r_rdy;
  assign vld_o      = r_vld;
  assign vector_o   = r_vector;
  assign err_o      = r_err;
  assign ram_en_o   = r_ram_en;
  assign ram_addr_o = r_ram_addr;

endmodule

// File: tb/tb_ivt_vector_fetch.sv
`timescale 1ns/1ps
// Bench for ivt_vector_fetch: three instances (RD_LAT 1/2/4) each with a latency-accurate RAM model.
module tb_ivt_vector_fetch;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [NI];
  logic        ack    [NI];
  logic        rdy    [NI];
  logic        vld    [NI];
  logic        ram_en [NI];
  logic [4:0]  core   [NI];
  logic [7:0]  vec    [NI];
  logic [31:0] vector [NI];
  logic [31:0] dout   [NI];
  logic [1:0]  err    [NI];
  logic [12:0] addr   [NI];
  logic [31:0] mem    [0:8191];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : gi
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      logic [31:0] pipe [LAT];
      ivt_vector_fetch #(.CORE_BITS(5), .VEC_BITS(8), .RD_LAT(LAT), .UNINIT_VEC(15)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[g]), .core_i(core[g]), .vec_i(vec[g]),
        .rdy_o(rdy[g]), .vld_o(vld[g]), .ack_i(ack[g]), .vector_o(vector[g]), .err_o(err[g]),
        .ram_en_o(ram_en[g]), .ram_addr_o(addr[g]), .ram_dout_i(dout[g]));
      // Output is garbage except exactly LAT cycles after an enabled read.
      always @(posedge clk) begin
        pipe[0] <= ram_en[g] ? mem[addr[g]] : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign dout[g] = pipe[LAT-1];
    end
  endgenerate

  // Read/valid monitor
  int          n_rd  [NI] = '{0, 0, 0};
  int          n_vld [NI] = '{0, 0, 0};
  int          n_dbl [NI] = '{0, 0, 0};
  logic        prev_en  [NI] = '{1'b0, 1'b0, 1'b0};
  logic        prev_vld [NI] = '{1'b0, 1'b0, 1'b0};
  logic [12:0] rd_log [NI][256];

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ram_en[k]) begin
        rd_log[k][n_rd[k] % 256] <= addr[k];
        n_rd[k] <= n_rd[k] + 1;
        if (prev_en[k]) n_dbl[k] <= n_dbl[k] + 1;
      end
      if (vld[k] && !prev_vld[k]) n_vld[k] <= n_vld[k] + 1;
      prev_en[k]  <= ram_en[k];
      prev_vld[k] <= vld[k];
    end
  end

  typedef struct {
    logic [31:0] v;
    logic [1:0]  e;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [4:0]  c;
    logic [7:0]  v;
    logic [31:0] prim;
    logic [31:0] uni;
    logic [31:0] ev;
    logic [1:0]  ee;
    int          nrd;
    logic        eack;
  } vec_t;
  vec_t tbl [7];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  // Called at a negedge; issues one request and checks the result when vld appears.
  task automatic fetch(input int k, input logic [4:0] c, input logic [7:0] v, input logic [31:0] ev,
                       input logic [1:0] ee, input int nrd, input logic eack, input bit do_ack);
    int   w, cnt, rd0;
    exp_t ex, got;
    w = 0;
    while (!rdy[k] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rdy_before_req", 32'(rdy[k]), 32'd1);
    rd0 = n_rd[k];
    core[k] = c;
    vec[k]  = v;
    req[k]  = 1'b1;
    ack[k]  = eack;
    ex.v = ev;
    ex.e = ee;
    ex.lat = lat_of(k) + 2 + (nrd - 1) * (lat_of(k) + 1);
    sbq.push_back(ex);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk("rdy_drop", 32'(rdy[k]), 32'd0);
      req[k] = 1'b0;
    end while (!vld[k] && cnt < 100);
    got = sbq.pop_front();
    chk("vector", vector[k], got.v);
    chk("err", 32'(err[k]), 32'(got.e));
    chk("latency", 32'(cnt), 32'(got.lat));
    chk("num_reads", 32'(n_rd[k] - rd0), 32'(nrd));
    chk("addr_first", 32'(rd_log[k][rd0 % 256]), 32'({c, v}));
    if (nrd == 2) chk("addr_retry", 32'(rd_log[k][(rd0 + 1) % 256]), 32'({c, 8'h0F}));
    if (do_ack) begin
      ack[k] = 1'b1;
      @(negedge clk);
      ack[k] = 1'b0;
      chk("rdy_after_ack", {30'd0, rdy[k], vld[k]}, 32'b10);
    end
  endtask

  initial begin
    int          r0, v0;
    logic [31:0] hv;
    logic [1:0]  he;

    for (int a = 0; a < 8192; a++) mem[a] = 32'h1000_0000 | 32'(a);
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; ack[k] = 1'b0; core[k] = '0; vec[k] = '0;
    end
    tbl[0] = '{5'd0,  8'hA5, 32'h0000_1234, 32'h0000_0055, 32'h0000_1234, 2'b00, 1, 1'b0};
    tbl[1] = '{5'd31, 8'h40, 32'h0,         32'h00FF_0000, 32'h00FF_0000, 2'b01, 2, 1'b0};
    tbl[2] = '{5'd2,  8'h03, 32'h0,         32'h0,         32'h0,         2'b10, 2, 1'b0};
    tbl[3] = '{5'd5,  8'h0F, 32'h0,         32'h0,         32'h0,         2'b10, 2, 1'b1};
    tbl[4] = '{5'd5,  8'h0F, 32'h0000_CAFE, 32'h0000_CAFE, 32'h0000_CAFE, 2'b00, 1, 1'b1};
    tbl[5] = '{5'd16, 8'hFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 1, 1'b0};
    tbl[6] = '{5'd9,  8'h10, 32'h0,         32'h8000_0000, 32'h8000_0000, 2'b01, 2, 1'b1};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_rdy_vld", {30'd0, rdy[k], vld[k]}, 32'b10);
      chk("rst_vector_err", vector[k] | 32'(err[k]), 32'd0);
      chk("rst_ram", {18'd0, ram_en[k], addr[k]}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven fetches on the RD_LAT=2 instance
    for (int i = 0; i < 7; i++) begin
      mem[{tbl[i].c, 8'h0F}] = tbl[i].uni;
      mem[{tbl[i].c, tbl[i].v}] = tbl[i].prim;
      fetch(1, tbl[i].c, tbl[i].v, tbl[i].ev, tbl[i].ee, tbl[i].nrd, tbl[i].eack, 1'b1);
      ack[1] = 1'b0;
      @(negedge clk);
    end

    // Result held in DONE while ack is low and req toggles
    mem[{5'd7, 8'h33}] = 32'h7777_0001;
    fetch(1, 5'd7, 8'h33, 32'h7777_0001, 2'b00, 1, 1'b0, 1'b0);
    hv = 32'h7777_0001;
    he = 2'b00;
    r0 = n_rd[1];
    for (int i = 0; i < 10; i++) begin
      req[1] = (i % 2 == 0);
      core[1] = 5'(i);
      @(negedge clk);
      chk("hold_vld_rdy", {30'd0, vld[1], rdy[1]}, 32'b10);
      chk("hold_data", vector[1] ^ 32'(err[1]), hv ^ 32'(he));
    end
    req[1] = 1'b0;
    chk("hold_no_reads", 32'(n_rd[1] - r0), 32'd0);
    ack[1] = 1'b1;
    @(negedge clk);
    ack[1] = 1'b0;
    chk("hold_release", {30'd0, rdy[1], vld[1]}, 32'b10);
    @(negedge clk);

    // Asynchronous reset in the cycle after ISSUE
    mem[{5'd3, 8'h21}] = 32'h3333_0021;
    core[1] = 5'd3;
    vec[1]  = 8'h21;
    req[1]  = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    chk("issue_pulse", {18'd0, ram_en[1], addr[1]}, {18'd0, 1'b1, 13'h0321});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_rdy_vld", {30'd0, rdy[1], vld[1]}, 32'b10);
    chk("arst_vector", vector[1], 32'd0);
    chk("arst_err", 32'(err[1]), 32'd0);
    chk("arst_ram", {18'd0, ram_en[1], addr[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = n_vld[1];
    repeat (10) @(negedge clk);
    chk("arst_no_vld", 32'(n_vld[1] - v0), 32'd0);
    fetch(1, 5'd3, 8'h21, 32'h3333_0021, 2'b00, 1, 1'b0, 1'b1);

    // Back-to-back with ack held high, all three latencies
    for (int k = 0; k < NI; k++) begin
      r0 = n_rd[k];
      v0 = n_vld[k];
      for (int n = 0; n < 4; n++) begin
        mem[{5'(20 + k), 8'(n * 7 + 1)}] = 32'hB000_0000 + 32'(k * 16 + n);
        fetch(k, 5'(20 + k), 8'(n * 7 + 1), 32'hB000_0000 + 32'(k * 16 + n), 2'b00, 1, 1'b1, 1'b0);
      end
      repeat (2) @(negedge clk);
      ack[k] = 1'b0;
      chk("b2b_results", 32'(n_vld[k] - v0), 32'd4);
      chk("b2b_reads", 32'(n_rd[k] - r0), 32'd4);
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) chk("ram_en_consecutive", 32'(n_dbl[k]), 32'd0);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
